// File: rtl/router_fsm.sv
// Purpose : control FSM for a 1-in / 3-out packet router; picks the output
//           FIFO from the header address, sequences header/payload/parity
//           loads and drives state-qualified strobes for the register block
//           and synchronizer.
// Latency : state advances one step per clk; outputs are pure decodes of the
//           state register (Moore), so they follow each state change with no
//           extra delay.
// Backpressure: a full destination FIFO parks the FSM in FIFO_FULL until it
//           drains; a non-empty destination at decode time parks it in
//           WAIT_TILL_EMPTY. While parked, busy=1 tells the source to hold
//           its data.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   pkt_valid             header/payload byte present on the input bus
//   parity_done           register block has captured the parity byte
//   soft_reset_0..2       per-output timeout; aborts a packet headed there
//   fifo_full             the currently selected FIFO is full
//   fifo_empty_0..2       per-output FIFO empty flags
//   low_pkt_valid         pkt_valid fell while stalled (parity pending)
//   din[1:0]              destination address (header bits [1:0])
//   busy                  source must hold the current byte
//   detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg
//                         one-hot state strobes
//   write_enb_reg         write the selected FIFO this cycle

module router_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic       parity_done,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       low_pkt_valid,
  input  logic [1:0] din,
  output logic       busy,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       lfd_state
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL          = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic din_empty;   // empty flag of the FIFO named by the incoming header
  logic addr_empty;  // empty flag of the FIFO this packet was latched for
  logic soft_hit;    // timeout on the output owning the current packet

  // Address 3 is not a port; it must never select a FIFO.
  always_comb begin
    din_empty = 1'b0;
    case (din)
      2'd0:    din_empty = fifo_empty_0;
      2'd1:    din_empty = fifo_empty_1;
      2'd2:    din_empty = fifo_empty_2;
      default: din_empty = 1'b0;
    endcase
  end

  always_comb begin
    addr_empty = 1'b0;
    case (addr_q)
      2'd0:    addr_empty = fifo_empty_0;
      2'd1:    addr_empty = fifo_empty_1;
      2'd2:    addr_empty = fifo_empty_2;
      default: addr_empty = 1'b0;
    endcase
  end

  // Timeouts on outputs other than the one we are feeding are irrelevant.
  always_comb begin
    soft_hit = (soft_reset_0 && (addr_q == 2'd0)) ||
               (soft_reset_1 && (addr_q == 2'd1)) ||
               (soft_reset_2 && (addr_q == 2'd2));
  end

  // Next-state and address capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    if ((state_q == DECODE_ADDRESS) && pkt_valid && (din != 2'd3)) begin
      addr_d = din;
    end

    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && (din != 2'd3)) begin
          state_d = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        // A full FIFO outranks end-of-packet: the last byte still needs a slot.
        if (fifo_full) begin
          state_d = FIFO_FULL;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      LOAD_PARITY: begin
        state_d = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL : DECODE_ADDRESS;
      end
      FIFO_FULL: begin
        if (!fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        // After a stall: parity may already be in, the packet may have ended
        // while stalled (parity still to load), or payload continues.
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (addr_empty) begin
          state_d = LOAD_FIRST_DATA;
        end
      end
      default: begin
        // Unknown encodings (e.g. X after power-up without reset) recover.
        state_d = DECODE_ADDRESS;
      end
    endcase

    // Timeout abort wins over every normal transition.
    if (soft_hit) begin
      state_d = DECODE_ADDRESS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore output decode. busy is low only where the input byte is consumed
  // immediately (DECODE_ADDRESS captures the header, LOAD_DATA writes payload).
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    full_state    = 1'b0;
    laf_state     = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FIFO_FULL: begin
        full_state = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

  logic       clk;
  logic       rst;
  logic       pkt_valid;
  logic       parity_done;
  logic [2:0] sr;
  logic       fifo_full;
  logic [2:0] fe;
  logic       low_pkt_valid;
  logic [1:0] din;
  logic       busy, detect_add, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, lfd_state;

  int checks   = 0;
  int failures = 0;

  // Expected output vectors, pushed as stimulus is driven, popped after the edge.
  logic [7:0] sb_q[$];
  logic [7:0] obs;
  logic [7:0] exp_v;

  typedef struct packed {
    logic       pv;
    logic       pd;
    logic [2:0] sr;
    logic       ff;
    logic [2:0] fe;
    logic       lpv;
    logic [1:0] din;
  } stim_t;

  localparam int S_DA  = 0;
  localparam int S_LFD = 1;
  localparam int S_LD  = 2;
  localparam int S_FF  = 3;
  localparam int S_LAF = 4;
  localparam int S_LP  = 5;
  localparam int S_CPE = 6;
  localparam int S_WTE = 7;

  router_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .parity_done   (parity_done),
    .soft_reset_0  (sr[0]),
    .soft_reset_1  (sr[1]),
    .soft_reset_2  (sr[2]),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fe[0]),
    .fifo_empty_1  (fe[1]),
    .fifo_empty_2  (fe[2]),
    .low_pkt_valid (low_pkt_valid),
    .din           (din),
    .busy          (busy),
    .detect_add    (detect_add),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .lfd_state     (lfd_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, detect_add, lfd, ld, full, laf, write_enb, rst_int}
  assign obs = {busy, detect_add, lfd_state, ld_state, full_state, laf_state,
                write_enb_reg, rst_int_reg};

  function automatic logic [7:0] exp_of(input int s);
    case (s)
      S_DA:    return 8'b0100_0000;
      S_LFD:   return 8'b1010_0000;
      S_LD:    return 8'b0001_0010;
      S_FF:    return 8'b1000_1000;
      S_LAF:   return 8'b1000_0110;
      S_LP:    return 8'b1000_0010;
      S_CPE:   return 8'b1000_0001;
      default: return 8'b1000_0000;
    endcase
  endfunction

  function automatic stim_t mk(input logic pv, input logic pd, input logic [2:0] s,
                               input logic ff, input logic [2:0] e, input logic lpv,
                               input logic [1:0] d);
    stim_t r;
    r.pv = pv; r.pd = pd; r.sr = s; r.ff = ff; r.fe = e; r.lpv = lpv; r.din = d;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = mk(0,0,3'b000,0,3'b111,0,2'd0);
    #1;
    checks++;
    if (obs !== exp_of(S_DA)) begin
      failures++;
      $display("FAIL reset_hold: outputs=%b required=%b", obs, exp_of(S_DA));
    end
    // A valid header under reset must not move the machine.
    pkt_valid = 1'b1; din = 2'd1;
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_of(S_DA)) begin
      failures++;
      $display("FAIL reset_dominates: outputs=%b required=%b", obs, exp_of(S_DA));
    end
    pkt_valid = 1'b0; din = 2'd0;
    rst = 1'b0;
  endtask

  task automatic test_normal();
    stim_t stv[$]; int stx[$];
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd1)); stx.push_back(S_LFD);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LP);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_CPE);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_DA);
    for (int i = 0; i < stv.size(); i++) begin
      {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = stv[i];
      sb_q.push_back(exp_of(stx[i]));
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL normal step %0d: outputs=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_full_stall();
    stim_t stv[$]; int stx[$];
    // Stall, then packet ended while stalled -> parity load.
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd1)); stx.push_back(S_LFD);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(1,0,3'b000,1,3'b111,0,2'd0)); stx.push_back(S_FF);
    stv.push_back(mk(0,0,3'b000,0,3'b111,1,2'd0)); stx.push_back(S_LAF);
    stv.push_back(mk(0,0,3'b000,0,3'b111,1,2'd0)); stx.push_back(S_LP);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_CPE);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_DA);
    // Stall with payload continuing -> back to LOAD_DATA; full again in CPE.
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LFD);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(1,0,3'b000,1,3'b111,0,2'd0)); stx.push_back(S_FF);
    stv.push_back(mk(1,0,3'b000,1,3'b111,0,2'd0)); stx.push_back(S_FF);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LAF);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LP);
    stv.push_back(mk(0,0,3'b000,1,3'b111,0,2'd0)); stx.push_back(S_CPE);
    stv.push_back(mk(0,0,3'b000,1,3'b111,0,2'd0)); stx.push_back(S_FF);
    stv.push_back(mk(0,1,3'b000,0,3'b111,1,2'd0)); stx.push_back(S_LAF);
    // parity_done outranks low_pkt_valid here.
    stv.push_back(mk(0,1,3'b000,0,3'b111,1,2'd0)); stx.push_back(S_DA);
    for (int i = 0; i < stv.size(); i++) begin
      {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = stv[i];
      sb_q.push_back(exp_of(stx[i]));
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL full_stall step %0d: outputs=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_wait_empty();
    stim_t stv[$]; int stx[$];
    stv.push_back(mk(1,0,3'b000,0,3'b011,0,2'd2)); stx.push_back(S_WTE);
    // Other FIFOs empty must not release a wait on FIFO 2.
    stv.push_back(mk(1,0,3'b000,0,3'b011,0,2'd0)); stx.push_back(S_WTE);
    stv.push_back(mk(1,0,3'b000,0,3'b100,0,2'd0)); stx.push_back(S_LFD);
    stv.push_back(mk(1,0,3'b000,0,3'b000,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(0,0,3'b000,0,3'b000,0,2'd0)); stx.push_back(S_LP);
    stv.push_back(mk(0,0,3'b000,0,3'b000,0,2'd0)); stx.push_back(S_CPE);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_DA);
    for (int i = 0; i < stv.size(); i++) begin
      {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = stv[i];
      sb_q.push_back(exp_of(stx[i]));
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL wait_empty step %0d: outputs=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_soft_reset();
    stim_t stv[$]; int stx[$];
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd1)); stx.push_back(S_LFD);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(1,0,3'b001,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(1,0,3'b100,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(1,0,3'b010,0,3'b111,0,2'd0)); stx.push_back(S_DA);
    // Packet to port 0, aborted while stalled (abort beats "stay full").
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LFD);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(1,0,3'b000,1,3'b111,0,2'd0)); stx.push_back(S_FF);
    stv.push_back(mk(1,0,3'b010,1,3'b111,0,2'd0)); stx.push_back(S_FF);
    stv.push_back(mk(0,0,3'b001,1,3'b111,0,2'd0)); stx.push_back(S_DA);
    for (int i = 0; i < stv.size(); i++) begin
      {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = stv[i];
      sb_q.push_back(exp_of(stx[i]));
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL soft_reset step %0d: outputs=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_invalid_addr();
    stim_t stv[$]; int stx[$];
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd3)); stx.push_back(S_DA);
    stv.push_back(mk(1,0,3'b000,0,3'b000,0,2'd3)); stx.push_back(S_DA);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd1)); stx.push_back(S_DA);
    for (int i = 0; i < stv.size(); i++) begin
      {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = stv[i];
      sb_q.push_back(exp_of(stx[i]));
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL invalid_addr step %0d: outputs=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t stv[$]; int stx[$];
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LFD);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LP);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_CPE);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd2)); stx.push_back(S_DA);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd2)); stx.push_back(S_LFD);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    for (int i = 0; i < stv.size(); i++) begin
      {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = stv[i];
      sb_q.push_back(exp_of(stx[i]));
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL back_to_back step %0d: outputs=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    stim_t stv[$]; int stx[$];
    // Machine is in LOAD_DATA on entry; reset asynchronously between edges.
    {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = mk(1,0,3'b000,0,3'b111,0,2'd0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== exp_of(S_DA)) begin
      failures++;
      $display("FAIL reset_mid_packet: outputs=%b required=%b", obs, exp_of(S_DA));
    end
    {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = mk(0,0,3'b000,0,3'b111,0,2'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    // Next packet must start cleanly.
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_DA);
    stv.push_back(mk(1,0,3'b000,0,3'b111,0,2'd2)); stx.push_back(S_LFD);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LD);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_LP);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_CPE);
    stv.push_back(mk(0,0,3'b000,0,3'b111,0,2'd0)); stx.push_back(S_DA);
    for (int i = 0; i < stv.size(); i++) begin
      {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = stv[i];
      sb_q.push_back(exp_of(stx[i]));
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL after_reset step %0d: outputs=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {pkt_valid, parity_done, sr, fifo_full, fe, low_pkt_valid, din} = mk(0,0,3'b000,0,3'b111,0,2'd0);
    @(posedge clk); #1;
    test_reset();
    test_normal();
    test_full_stall();
    test_wait_empty();
    test_soft_reset();
    test_invalid_addr();
    test_back_to_back();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
